// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Arbitrates the register file's single write port between the main pipeline
// write-back (requester A, fixed high priority) and the mul/div unit
// (requester B, buffered in a small FIFO). A B entry that keeps losing to A
// has an anti-starvation counter that eventually forces it through. pend1 and
// pend2 tell decode when a source register still has a queued or in-flight write.

module wb_port_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_num,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_num,
  input  logic [31:0] b_data,
  output logic        reg_wr,
  output logic [4:0]  wr_num,
  output logic [31:0] wr_data,
  input  logic [4:0]  read1,
  input  logic [4:0]  read2,
  output logic        pend1,
  output logic        pend2
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [3:0]    MAX_WAIT_C = 4'(MAX_WAIT);

  // B queue storage and bookkeeping
  logic [4:0]    q_num_r  [FIFO_DEPTH];
  logic [31:0]   q_data_r [FIFO_DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;

  // Anti-starvation state
  logic [3:0]    wait_r;
  logic          force_r;

  // Registered write-port outputs
  logic          reg_wr_r;
  logic [4:0]    wr_num_r;
  logic [31:0]   wr_data_r;

  // Per-cycle decisions
  logic          nonempty_s;
  logic          b_ready_s;
  logic          enq_s;
  logic          issue_a_s;
  logic          issue_b_s;
  logic          pend1_s;
  logic          pend2_s;

  assign nonempty_s = (count_r != {CW{1'b0}});
  assign b_ready_s  = (count_r != DEPTH_C);
  // Register-0 requests from B are accepted but never stored.
  assign enq_s      = b_valid & b_ready_s & (b_num != 5'd0);
  // The head wins when forced, or whenever A has nothing to write.
  assign issue_b_s  = nonempty_s & (force_r | ~a_valid);
  assign issue_a_s  = a_valid & ~force_r;

  assign a_ready = ~force_r;
  assign b_ready = b_ready_s;
  assign reg_wr  = reg_wr_r;
  assign wr_num  = wr_num_r;
  assign wr_data = wr_data_r;
  assign pend1   = pend1_s;
  assign pend2   = pend2_s;

  // Next queue occupancy from simultaneous enqueue/dequeue
  always_comb begin
    case ({enq_s, issue_b_s})
      2'b10:   count_nx_s = count_r + CW'(1);
      2'b01:   count_nx_s = count_r - CW'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // Pending-write lookup: any live queue slot or the write currently on the port
  always_comb begin
    pend1_s = 1'b0;
    pend2_s = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      // A physical slot is live when its distance from head is below count.
      pend1_s = pend1_s | (({1'b0, PW'(i) - head_r} < count_r) & (q_num_r[i] == read1));
      pend2_s = pend2_s | (({1'b0, PW'(i) - head_r} < count_r) & (q_num_r[i] == read2));
    end
    pend1_s = (pend1_s | (reg_wr_r & (wr_num_r == read1))) & (read1 != 5'd0);
    pend2_s = (pend2_s | (reg_wr_r & (wr_num_r == read2))) & (read2 != 5'd0);
  end

  // B queue: store new entries at tail, retire head when it wins the port
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_num_r[i]  <= 5'd0;
        q_data_r[i] <= 32'd0;
      end
    end else begin
      if (enq_s) begin
        q_num_r[tail_r]  <= b_num;
        q_data_r[tail_r] <= b_data;
        tail_r           <= tail_r + PW'(1);
      end
      if (issue_b_s) begin
        head_r <= head_r + PW'(1);
      end
      count_r <= count_nx_s;
    end
  end

  // Starvation tracking: count lost cycles of a waiting head, force it at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r  <= 4'd0;
      force_r <= 1'b0;
    end else if (!nonempty_s || issue_b_s) begin
      wait_r  <= 4'd0;
      force_r <= 1'b0;
    end else begin
      wait_r <= wait_r + 4'd1;
      if (wait_r + 4'd1 == MAX_WAIT_C) begin
        force_r <= 1'b1;
      end
    end
  end

  // Write-port register: load the winner, or deassert the enable when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_r  <= 1'b0;
      wr_num_r  <= 5'd0;
      wr_data_r <= 32'd0;
    end else if (issue_b_s) begin
      reg_wr_r  <= 1'b1;
      wr_num_r  <= q_num_r[head_r];
      wr_data_r <= q_data_r[head_r];
    end else if (issue_a_s) begin
      // A write to register 0 still takes the slot but must not commit.
      reg_wr_r  <= (a_num != 5'd0);
      wr_num_r  <= a_num;
      wr_data_r <= a_data;
    end else begin
      reg_wr_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (FIFO_DEPTH=2, MAX_WAIT=4).
// Each scenario task pushes the writes it expects onto a scoreboard in the
// order they must reach the register file; a negedge monitor pops and compares
// every asserted write.

module tb_wb_port_arbiter;

  typedef struct packed {
    logic [4:0]  num;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_num;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_num;
  logic [31:0] b_data;
  logic        reg_wr;
  logic [4:0]  wr_num;
  logic [31:0] wr_data;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic        pend1;
  logic        pend2;

  int  errors = 0;
  int  checks = 0;
  wr_t sb[$];

  wb_port_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_num(a_num), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_num(b_num), .b_data(b_data),
    .reg_wr(reg_wr), .wr_num(wr_num), .wr_data(wr_data),
    .read1(read1), .read2(read2), .pend1(pend1), .pend2(pend2)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every asserted write must match the oldest expectation
  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got num=%0d data=%h, expected no write", wr_num, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wr_num !== e.num || wr_data !== e.data) begin
          errors++;
          $display("FAIL write_order: got num=%0d data=%h, expected num=%0d data=%h",
                   wr_num, wr_data, e.num, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic [4:0] n, input logic [31:0] d);
    wr_t e;
    e.num  = n;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; a_num = 5'd1; a_data = 32'h0000_1111;
    b_valid = 1'b1; b_num = 5'd3; b_data = 32'h0000_3333;
    read1 = 5'd3; read2 = 5'd4;
    push_exp(5'd1, 32'h0000_1111);
    next();
    b_num = 5'd4; b_data = 32'h0000_4444; a_data = 32'h0000_1112;
    push_exp(5'd1, 32'h0000_1112);
    next();
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (pend1 !== 1'b1) begin errors++; $display("FAIL rst_pre_pend1: got %0b expected 1", pend1); end
    checks++; if (pend2 !== 1'b1) begin errors++; $display("FAIL rst_pre_pend2: got %0b expected 1", pend2); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_full: got b_ready=%0b expected 0", b_ready); end
    next();
    rst = 1'b0;
    #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL rst_reg_wr: got %0b expected 0", reg_wr); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %0b expected 1", b_ready); end
    checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL rst_pend1: got %0b expected 0", pend1); end
    checks++; if (pend2 !== 1'b0) begin errors++; $display("FAIL rst_pend2: got %0b expected 0", pend2); end
    checks++; if (wr_num !== 5'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_regs: got num=%0d data=%h expected 0/0", wr_num, wr_data); end
    repeat (4) next();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_a_alone();
    a_valid = 1'b1; a_num = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_ready_pre: got %0b expected 1", a_ready); end
    push_exp(5'd5, 32'hDEAD_BEEF);
    next();
    a_valid = 1'b0;
    #1;
    checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL a_reg_wr: got %0b expected 1", reg_wr); end
    checks++; if (wr_num !== 5'd5) begin errors++; $display("FAIL a_wr_num: got %0d expected 5", wr_num); end
    checks++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL a_wr_data: got %h expected deadbeef", wr_data); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_ready_post: got %0b expected 1", a_ready); end
    next();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL a_one_cycle: got %0b expected 0", reg_wr); end
    checks++; if (wr_num !== 5'd5) begin errors++; $display("FAIL a_hold_num: got %0d expected 5", wr_num); end
  endtask

  task automatic test_b_alone();
    b_valid = 1'b1; b_num = 5'd7; b_data = 32'h1234_5678; read1 = 5'd7; read2 = 5'd9;
    #1;
    checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL b_pend_before: got %0b expected 0", pend1); end
    push_exp(5'd7, 32'h1234_5678);
    next();
    b_valid = 1'b0;
    #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL b_no_bypass: got %0b expected 0", reg_wr); end
    checks++; if (pend1 !== 1'b1) begin errors++; $display("FAIL b_pend_queued: got %0b expected 1", pend1); end
    checks++; if (pend2 !== 1'b0) begin errors++; $display("FAIL b_pend2_other: got %0b expected 0", pend2); end
    next();
    checks++; if (reg_wr !== 1'b1 || wr_num !== 5'd7) begin errors++; $display("FAIL b_issue: got wr=%0b num=%0d expected 1/7", reg_wr, wr_num); end
    checks++; if (pend1 !== 1'b1) begin errors++; $display("FAIL b_pend_inflight: got %0b expected 1", pend1); end
    next();
    checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL b_pend_after: got %0b expected 0", pend1); end
  endtask

  task automatic test_starvation();
    logic [31:0] ad;
    a_valid = 1'b1; a_num = 5'd10; a_data = 32'hA000_0000;
    b_valid = 1'b1; b_num = 5'd11; b_data = 32'hB000_0000;
    push_exp(5'd10, 32'hA000_0000);
    next();
    b_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ad = 32'hA000_0000 + 32'(k);
      a_data = ad;
      push_exp(5'd10, ad);
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL starve_a_wins_%0d: got a_ready=%0b expected 1", k, a_ready); end
      next();
    end
    a_data = 32'hA000_0005;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL starve_force: got a_ready=%0b expected 0", a_ready); end
    push_exp(5'd11, 32'hB000_0000);
    push_exp(5'd10, 32'hA000_0005);
    next();
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL starve_release: got a_ready=%0b expected 1", a_ready); end
    checks++; if (wr_num !== 5'd11) begin errors++; $display("FAIL starve_b_written: got num=%0d expected 11", wr_num); end
    next();
    a_valid = 1'b0;
    repeat (2) next();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL starve_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_full_queue();
    a_valid = 1'b1; a_num = 5'd12; a_data = 32'hC000_0000;
    b_valid = 1'b1; b_num = 5'd13; b_data = 32'hD000_0000;
    push_exp(5'd12, 32'hC000_0000);
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL full_ready0: got %0b expected 1", b_ready); end
    next();
    a_data = 32'hC000_0001; b_num = 5'd14; b_data = 32'hD000_0001;
    push_exp(5'd12, 32'hC000_0001);
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %0b expected 1", b_ready); end
    next();
    a_data = 32'hC000_0002; b_num = 5'd15; b_data = 32'hD000_0002;
    push_exp(5'd12, 32'hC000_0002);
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_block: got %0b expected 0", b_ready); end
    next();
    a_valid = 1'b0;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_deq_same_cycle: got %0b expected 0", b_ready); end
    push_exp(5'd13, 32'hD000_0000);
    next();
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL full_freed: got %0b expected 1", b_ready); end
    push_exp(5'd14, 32'hD000_0001);
    next();
    b_valid = 1'b0;
    push_exp(5'd15, 32'hD000_0002);
    repeat (3) next();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_reg0();
    a_valid = 1'b1; a_num = 5'd0; a_data = 32'h5555_5555;
    b_valid = 1'b1; b_num = 5'd0; b_data = 32'h6666_6666;
    read1 = 5'd0; read2 = 5'd0;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL r0_accept: got a=%0b b=%0b expected 1/1", a_ready, b_ready); end
    next();
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL r0_no_write: got %0b expected 0", reg_wr); end
    checks++; if (dut.count_r !== 2'd0) begin errors++; $display("FAIL r0_count: got %0d expected 0", dut.count_r); end
    checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL r0_pend1: got %0b expected 0", pend1); end
    repeat (3) next();
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; a_num = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_num = 5'd0; b_data = 32'd0; read1 = 5'd0; read2 = 5'd0;
    repeat (3) next();
    rst = 1'b0;
    next();
    test_reset();
    test_a_alone();
    test_b_alone();
    test_starvation();
    test_full_queue();
    test_reg0();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL final_drain: got %0d pending expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
